// File: rtl/logit_pla_if.sv
// logit_pla_if: streaming bus for the piecewise-linear logit block.
//   in_valid/in_ready/in_data      : probability y in, signed Q4.11
//   out_valid/out_ready/out_data   : recovered x out, signed Q4.11
//   out_sat                        : result was clamped, qualified by out_valid
//   sat_cnt / sat_cnt_clr          : saturation event counter and its clear
// The block under test takes the slave modport; the producer/consumer
// side takes the master modport.
interface logit_pla_if #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_sat;
  logic [CNT_W-1:0]     sat_cnt;
  logic                 sat_cnt_clr;

  modport master (
    output in_valid, in_data, out_ready, sat_cnt_clr,
    input  in_ready, out_valid, out_data, out_sat, sat_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, sat_cnt_clr,
    output in_ready, out_valid, out_data, out_sat, sat_cnt
  );
endinterface

// File: rtl/logit_pla.sv
// logit_pla: piecewise-linear inverse sigmoid in signed Q4.11 (1.0 = 2048).
// Recovers a pre-activation x from a stored activation y, inverting the
// segmented sigmoid approximation used elsewhere in the datapath.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : logit_pla_if slave modport (valid/ready in and out, out_sat,
//          sat_cnt, sat_cnt_clr)
// Two pipeline stages: S1 classifies y and subtracts the segment offset,
// S2 applies the segment slope (a left shift) or forces saturation.
module logit_pla #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  logit_pla_if.slave  bus
);

  // Segment codes ordered from most negative y to most positive y.
  typedef enum logic [2:0] {
    SEG_LO,  // y <= 0          : x = -10240, saturated
    SEG_E,   // 0 < y < 160     : x = 32*(y-320)
    SEG_D,   // 160 <= y < 512  : x = 8*(y-768)
    SEG_C,   // 512 <= y <= 1536: x = 4*(y-1024)
    SEG_B,   // 1536 < y <= 1888: x = 8*(y-1280)
    SEG_A,   // 1888 < y < 2048 : x = 32*(y-1728)
    SEG_HI   // y >= 2048       : x = +10240, saturated
  } seg_t;

  localparam logic signed [DW-1:0] SAT_POS = 16'sd10240;
  localparam logic signed [DW-1:0] SAT_NEG = -16'sd10240;

  logic signed [DW-1:0] y;
  seg_t                 seg_next;
  logic signed [16:0]   offset;
  logic signed [16:0]   d_next;

  seg_t                 s1_seg;
  logic signed [16:0]   s1_d;
  logic                 s1_valid;

  logic signed [20:0]   x_wide;
  logic signed [DW-1:0] x_next;
  logic                 sat_next;

  logic                 s2_adv;
  logic                 in_fire;
  logic                 out_fire;

  assign y        = bus.in_data;
  assign s2_adv   = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;
  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  // Classify y with full signed compares so that negative inputs fall
  // straight into the low saturation segment instead of aliasing upward.
  always_comb begin
    seg_next = SEG_LO;
    offset   = 17'sd0;
    if (y >= 16'sd2048) begin
      seg_next = SEG_HI;
    end else if (y > 16'sd1888) begin
      seg_next = SEG_A;
      offset   = 17'sd1728;
    end else if (y > 16'sd1536) begin
      seg_next = SEG_B;
      offset   = 17'sd1280;
    end else if (y >= 16'sd512) begin
      seg_next = SEG_C;
      offset   = 17'sd1024;
    end else if (y >= 16'sd160) begin
      seg_next = SEG_D;
      offset   = 17'sd768;
    end else if (y > 16'sd0) begin
      seg_next = SEG_E;
      offset   = 17'sd320;
    end
    d_next = 17'(y) - offset;
  end

  // Stage S1 holds its item until S2 can take it; it reloads whenever it
  // is empty or draining into S2 this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_seg   <= SEG_LO;
      s1_d     <= 17'sd0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_seg <= seg_next;
        s1_d   <= d_next;
      end
    end
  end

  // Apply the segment slope. The shift is done at 21 bits; the segment
  // table keeps every non-saturated result inside the 16-bit range, so
  // dropping the top bits is lossless.
  always_comb begin
    x_wide   = 21'sd0;
    sat_next = 1'b0;
    case (s1_seg)
      SEG_A, SEG_E: x_wide = 21'(s1_d) <<< 5;
      SEG_B, SEG_D: x_wide = 21'(s1_d) <<< 3;
      SEG_C:        x_wide = 21'(s1_d) <<< 2;
      SEG_HI: begin
        x_wide   = 21'(SAT_POS);
        sat_next = 1'b1;
      end
      default: begin
        x_wide   = 21'(SAT_NEG);
        sat_next = 1'b1;
      end
    endcase
    x_next = x_wide[DW-1:0];
  end

  // Stage S2 is the output register; it only moves when the consumer
  // has taken the current word (or there is none), which keeps out_data
  // and out_sat frozen during a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_data <= x_next;
        bus.out_sat  <= sat_next;
      end
    end
  end

  // Count delivered saturated results. Clear wins over a same-cycle
  // increment, and the count sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sat_cnt <= '0;
    end else if (bus.sat_cnt_clr) begin
      bus.sat_cnt <= '0;
    end else if (out_fire && bus.out_sat && !(&bus.sat_cnt)) begin
      bus.sat_cnt <= bus.sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_logit_pla.sv
// tb_logit_pla: self-checking bench for logit_pla.
// Expected results are pushed to a scoreboard queue when an input transfer
// happens and compared against the DUT output on the falling edge.
`timescale 1ns/1ps
module tb_logit_pla;

  localparam int DW    = 16;
  localparam int CNT_W = 4;

  typedef struct {
    int y;
    int x;
    bit sat;
  } vec_t;

  typedef struct {
    int x;
    bit sat;
    int tol;
    bit chk_sat;
  } sb_t;

  logic clk = 1'b0;
  logic rst;

  logit_pla_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

  logit_pla #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  sb_t  sb[$];
  sb_t  head;
  int   checks = 0;
  int   failures = 0;
  bit   random_ready = 1'b0;
  vec_t vecs[17];

  // Reference logit, written straight from the segment formulas.
  function automatic int logitModel(input int y);
    if (y >= 2048)     return 10240;
    else if (y > 1888) return 32 * (y - 1728);
    else if (y > 1536) return 8 * (y - 1280);
    else if (y >= 512) return 4 * (y - 1024);
    else if (y >= 160) return 8 * (y - 768);
    else if (y > 0)    return 32 * (y - 320);
    else               return -10240;
  endfunction

  // Forward sigmoid approximation whose inverse is the logit above.
  function automatic int sigmoidModel(input int x);
    if (x >= 10240)  return 2048;
    if (x >= 5152)   return 1728 + (x >>> 5);
    if (x > 2048)    return 1280 + (x >>> 3);
    if (x >= -2048)  return 1024 + (x >>> 2);
    if (x >= -4864)  return 768 + (x >>> 3);
    if (x > -10240)  return 320 + (x >>> 5);
    return 0;
  endfunction

  function automatic sb_t mkEntry(input int x, input bit sat, input int tol, input bit chk_sat);
    sb_t e;
    e.x = x;
    e.sat = sat;
    e.tol = tol;
    e.chk_sat = chk_sat;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected, input int tol);
    int diff;
    diff = actual - expected;
    if (diff < 0) diff = -diff;
    checks++;
    if (diff > tol) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (tol %0d) at %0t", name, actual, expected, tol, $time);
    end
  endtask

  // Monitor: compare whatever is on the output against the scoreboard head
  // every cycle it is valid (so stalled words must stay put), pop on a
  // transfer, and check that in_ready only drops with both stages full.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("in_ready_occupancy", int'(bus.in_ready),
                  (sb.size() >= 2 && !bus.out_ready) ? 0 : 1, 0);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output: got %0d expected no output", bus.out_data);
        end else begin
          head = sb[0];
          checkOutput("out_data", int'(bus.out_data), head.x, head.tol);
          if (head.chk_sat) checkOutput("out_sat", int'(bus.out_sat), int'(head.sat), 0);
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one input and hold it until accepted; the expected result is
  // queued on the edge where the transfer happens.
  task automatic applyStimulus(input int y, input sb_t e);
    bit rdy;
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(y);
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) sb.push_back(e);
      #1;
      if (random_ready) bus.out_ready = 1'($urandom_range(0, 1));
      guard++;
    end while (!rdy && guard < 100);
    if (!rdy) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 expected acceptance of %0d", y);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || bus.out_valid) && guard < 200) begin
      tick(1);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic pulseClear();
    bus.sat_cnt_clr = 1'b1;
    tick(1);
    bus.sat_cnt_clr = 1'b0;
  endtask

  // Input presented in cycle 0 must show on out_valid in cycle 2, not 1.
  task automatic checkLatency(input int y);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'(y);
    @(negedge clk);
    checkOutput("lat_in_ready", int'(bus.in_ready), 1, 0);
    @(posedge clk);
    sb.push_back(mkEntry(logitModel(y), (y >= 2048 || y <= 0), 0, 1'b1));
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("lat_cycle1_valid", int'(bus.out_valid), 0, 0);
    @(posedge clk);
    #1;
    checkOutput("lat_cycle2_valid", int'(bus.out_valid), 1, 0);
    waitDrain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs = '{
      '{1024, 0, 1'b0}, '{1536, 2048, 1'b0}, '{1920, 6144, 1'b0},
      '{256, -4096, 1'b0}, '{80, -7680, 1'b0},
      '{2048, 10240, 1'b1}, '{32767, 10240, 1'b1}, '{0, -10240, 1'b1},
      '{-1, -10240, 1'b1}, '{-32768, -10240, 1'b1},
      '{159, -5152, 1'b0}, '{160, -4864, 1'b0}, '{511, -2056, 1'b0},
      '{512, -2048, 1'b0}, '{1888, 4864, 1'b0},
      // 1889 sits in the steep segment: 32*(1889-1728)
      '{1889, 5152, 1'b0}, '{2047, 10208, 1'b0}
    };

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    bus.sat_cnt_clr = 1'b0;
    #12;
    checkOutput("rst_out_valid", int'(bus.out_valid), 0, 0);
    checkOutput("rst_out_data", int'(bus.out_data), 0, 0);
    checkOutput("rst_out_sat", int'(bus.out_sat), 0, 0);
    checkOutput("rst_sat_cnt", int'(bus.sat_cnt), 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_in_ready", int'(bus.in_ready), 1, 0);
    bus.out_ready = 1'b1;

    // Table vectors, streamed back to back.
    for (int i = 0; i < 17; i++)
      applyStimulus(vecs[i].y, mkEntry(vecs[i].x, vecs[i].sat, 0, 1'b1));
    waitDrain();
    checkOutput("sat_cnt_after_table", int'(bus.sat_cnt), 5, 0);
    pulseClear();
    checkOutput("sat_cnt_cleared", int'(bus.sat_cnt), 0, 0);

    checkLatency(1024);

    // Clear coincident with a saturated transfer.
    bus.out_ready = 1'b0;
    applyStimulus(2048, mkEntry(10240, 1'b1, 0, 1'b1));
    tick(2);
    bus.out_ready = 1'b1;
    bus.sat_cnt_clr = 1'b1;
    tick(1);
    bus.sat_cnt_clr = 1'b0;
    checkOutput("clr_beats_inc", int'(bus.sat_cnt), 0, 0);
    waitDrain();

    // Counter sticks at all-ones.
    for (int i = 0; i < 17; i++)
      applyStimulus((i % 2 == 0) ? 2048 : -5, mkEntry((i % 2 == 0) ? 10240 : -10240, 1'b1, 0, 1'b1));
    waitDrain();
    checkOutput("sat_cnt_saturates", int'(bus.sat_cnt), (1 << CNT_W) - 1, 0);
    pulseClear();

    // Random backpressure over a back-to-back stream.
    random_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int y;
      y = int'($urandom_range(0, 2300)) - 100;
      applyStimulus(y, mkEntry(logitModel(y), (y >= 2048 || y <= 0), 0, 1'b1));
    end
    random_ready = 1'b0;
    bus.out_ready = 1'b1;
    waitDrain();

    // Reset while both stages hold data.
    pulseClear();
    applyStimulus(0, mkEntry(-10240, 1'b1, 0, 1'b1));
    waitDrain();
    bus.out_ready = 1'b0;
    applyStimulus(600, mkEntry(-1696, 1'b0, 0, 1'b1));
    applyStimulus(700, mkEntry(-1296, 1'b0, 0, 1'b1));
    @(negedge clk);
    checkOutput("full_in_ready", int'(bus.in_ready), 0, 0);
    checkOutput("pre_reset_sat_cnt", int'(bus.sat_cnt), 1, 0);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("midrst_out_valid", int'(bus.out_valid), 0, 0);
    checkOutput("midrst_sat_cnt", int'(bus.sat_cnt), 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    checkLatency(512);

    // Round trip through the sigmoid approximation.
    for (int x = -10240; x <= 10240; x += 337) begin
      if ((x > 4864 && x < 5152) || (x > -5152 && x < -4864)) continue;
      applyStimulus(sigmoidModel(x), mkEntry(x, 1'b0, 32, 1'b0));
    end
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
